// File: rtl/forward_sub_4x4.sv
// Forward substitution for a 4x4 unit-lower-triangular system L*y = b.
// One multiply-accumulate per clock; a full solve spends 10 cycles in CALC.
//
// state | meaning
// IDLE  | waiting for start; y_out holds the last solution
// CALC  | one MAC (j<i) or one y[i] write-back (j==i) per cycle
// FIN   | done pulse for one cycle
module forward_sub_4x4 #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [16*WIDTH-1:0]   L_in,
    input  logic [4*WIDTH-1:0]    b_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*WIDTH-1:0]    y_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   l_q [16];
    logic [WIDTH-1:0]   b_q [4];
    logic [WIDTH-1:0]   y_q [4];
    logic [1:0]         i_q, j_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   l_ij, prod;
    logic               row_end;

    assign l_ij    = l_q[{i_q, j_q}];
    // low WIDTH bits of the product are identical for signed and unsigned operands
    assign prod    = l_ij * y_q[j_q];
    assign row_end = (j_q == i_q);

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (row_end && (i_q == 2'd3)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            acc_q   <= '0;
            for (int k = 0; k < 16; k++) begin
                l_q[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                b_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 16; k++) begin
                            l_q[k] <= L_in[WIDTH*k +: WIDTH];
                        end
                        for (int k = 0; k < 4; k++) begin
                            b_q[k] <= b_in[WIDTH*k +: WIDTH];
                        end
                        i_q   <= 2'd0;
                        j_q   <= 2'd0;
                        acc_q <= b_in[WIDTH-1:0];
                    end
                end
                CALC: begin
                    if (!row_end) begin
                        acc_q <= acc_q - prod;
                        j_q   <= j_q + 2'd1;
                    end else begin
                        y_q[i_q] <= acc_q;
                        if (i_q != 2'd3) begin
                            i_q   <= i_q + 2'd1;
                            j_q   <= 2'd0;
                            acc_q <= b_q[i_q + 2'd1];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_yout
        assign y_out[WIDTH*g +: WIDTH] = y_q[g];
    end

endmodule

// File: tb/tb_forward_sub_4x4.sv
// Self-checking bench for forward_sub_4x4: directed cases plus random solves
// compared against a plain-arithmetic model of L*y = b.
module tb_forward_sub_4x4;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [16*W-1:0]  L_in;
    logic [4*W-1:0]   b_in;
    logic             busy;
    logic             done;
    logic [4*W-1:0]   y_out;

    int checks = 0;
    int errors = 0;

    forward_sub_4x4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .L_in  (L_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .y_out (y_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16*W-1:0] pack16(input int m[16]);
        logic [16*W-1:0] v;
        for (int k = 0; k < 16; k++) v[W*k +: W] = m[k];
        return v;
    endfunction

    function automatic logic [4*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    endfunction

    // y[i] = b[i] - sum_{j<i} L[i][j]*y[j], all modulo 2^32
    function automatic logic [4*W-1:0] ref_solve(input logic [16*W-1:0] l, input logic [4*W-1:0] b);
        logic [W-1:0] y [4];
        logic [W-1:0] s;
        logic [W-1:0] lij;
        logic [4*W-1:0] r;
        for (int i = 0; i < 4; i++) begin
            s = b[W*i +: W];
            for (int j = 0; j < i; j++) begin
                lij = l[W*(4*i+j) +: W];
                s = s - lij * y[j];
            end
            y[i] = s;
        end
        for (int i = 0; i < 4; i++) r[W*i +: W] = y[i];
        return r;
    endfunction

    // Drives one start pulse and watches 14 cycles (k = cycles after the accepting edge).
    task automatic run_solve(input logic [16*W-1:0] l, input logic [4*W-1:0] b,
                             input int extra_at, input int rst_at,
                             output int done_cnt, output int done_at, output int busy_cnt,
                             output logic [4*W-1:0] y_done, output logic [4*W-1:0] y_end);
        done_cnt = 0;
        done_at  = -1;
        busy_cnt = 0;
        y_done   = 'x;
        @(negedge clk);
        L_in  = l;
        b_in  = b;
        start = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_at = k;
                y_done  = y_out;
            end
            if (busy) busy_cnt++;
            if (rst_at >= 0 && k == rst_at + 1) begin
                check("rst_mid_busy", {127'd0, busy}, 128'd0);
                check("rst_mid_done", {127'd0, done}, 128'd0);
                check("rst_mid_y", y_out, 128'd0);
            end
            start = (k == extra_at);
            if (k == extra_at) b_in = pack4(1, 1, 1, 1);
            rst = (k == rst_at);
        end
        y_end = y_out;
    endtask

    int              dc, da, bc;
    logic [4*W-1:0]  yd, ye, exp_y;
    logic [16*W-1:0] l_nom, l_diag, l_wrap, l_rand;
    logic [4*W-1:0]  b_nom, b_wrap, b_rand;
    int              d_first, d_second, d_count;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        L_in  = '0;
        b_in  = '0;
        l_nom  = pack16('{1, 0, 0, 0,  2, 1, 0, 0,  -1, 3, 1, 0,  0, 2, -2, 1});
        l_diag = pack16('{5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                          2, 5, 32'hDEADBEEF, 32'hDEADBEEF,
                          -1, 3, 5, 32'hDEADBEEF,
                          0, 2, -2, 5});
        l_wrap = pack16('{1, 0, 0, 0,  2, 1, 0, 0,  0, 0, 1, 0,  0, 0, 0, 1});
        b_nom  = pack4(18, 43, 8, 10);
        b_wrap = pack4(32'h7FFFFFFF, 0, 0, 0);
        exp_y  = pack4(18, 7, 5, 6);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_done", {127'd0, done}, 128'd0);
        check("reset_y", y_out, 128'd0);

        // nominal
        run_solve(l_nom, b_nom, -1, -1, dc, da, bc, yd, ye);
        check("nom_done_cnt", 128'(dc), 128'd1);
        check("nom_done_at", 128'(da), 128'd10);
        check("nom_busy_cycles", 128'(bc), 128'd11);
        check("nom_y", yd, exp_y);
        check("nom_model", ref_solve(l_nom, b_nom), exp_y);
        check("nom_y_held", ye, exp_y);

        // diagonal and upper triangle ignored
        run_solve(l_diag, b_nom, -1, -1, dc, da, bc, yd, ye);
        check("diag_done_at", 128'(da), 128'd10);
        check("diag_y", yd, exp_y);

        // modular wrap
        run_solve(l_wrap, b_wrap, -1, -1, dc, da, bc, yd, ye);
        check("wrap_y", yd, pack4(32'h7FFFFFFF, 2, 0, 0));

        // start while busy is ignored
        run_solve(l_nom, b_nom, 3, -1, dc, da, bc, yd, ye);
        check("busy_start_done_cnt", 128'(dc), 128'd1);
        check("busy_start_done_at", 128'(da), 128'd10);
        check("busy_start_busy_cycles", 128'(bc), 128'd11);
        check("busy_start_y", yd, exp_y);

        // reset mid-solve, then a clean nominal solve
        run_solve(l_nom, b_nom, -1, 4, dc, da, bc, yd, ye);
        check("rst_no_done", 128'(dc), 128'd0);
        check("rst_busy_cycles", 128'(bc), 128'd5);
        check("rst_y_after", ye, 128'd0);
        run_solve(l_nom, b_nom, -1, -1, dc, da, bc, yd, ye);
        check("after_rst_y", yd, exp_y);

        // start held high: back-to-back solves every 12 cycles
        d_first = -1; d_second = -1; d_count = 0;
        @(negedge clk);
        L_in  = l_nom;
        b_in  = b_nom;
        start = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (done) begin
                d_count++;
                if (d_first < 0) d_first = k; else d_second = k;
                check("held_y", y_out, exp_y);
            end
            if (k == 23) start = 1'b0;
        end
        check("held_done_cnt", 128'(d_count), 128'd2);
        check("held_first", 128'(d_first), 128'd10);
        check("held_second", 128'(d_second), 128'd22);
        repeat (14) @(negedge clk);
        check("held_idle_busy", {127'd0, busy}, 128'd0);

        // randomized solves (diagonal/upper entries random too, must be ignored)
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 16; k++) l_rand[W*k +: W] = (t < 10) ? $urandom_range(0, 15) - 8 : $urandom;
            for (int k = 0; k < 4; k++)  b_rand[W*k +: W] = $urandom;
            run_solve(l_rand, b_rand, -1, -1, dc, da, bc, yd, ye);
            check("rand_done_at", 128'(da), 128'd10);
            check("rand_y", yd, ref_solve(l_rand, b_rand));
        end

        // chain: backward stage samples y_out on done
        run_solve(l_nom, b_nom, -1, -1, dc, da, bc, yd, ye);
        check("chain_y_into_backward", yd, pack4(18, 7, 5, 6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
